dmem_responder: RTL and testbench

Responder end of the core's data-memory request interface: accepts one load or store request at a time from the load/store issue logic, holds it for a fixed access latency, then returns a single-cycle response. The response carries read data that is byte/half/word-aligned and zero- or sign-extended per the RV32I `funct3` encoding. It sits between the reservation-station load/store path and a synchronous word-organised storage array, replacing the ad-hoc start/busy RAM model.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I width codes, FSM states,
// and the load-lane select/extend helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // lane is the already-aligned byte offset of the access within the word
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [2:0]  fun3,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lane, 3'b000});
        h = 16'(word >> {lane[1], 4'b0000});
        case (fun3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_W:    r = word;
            F3_BU:   r = {24'd0, b};
            F3_HU:   r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous word array: byte-enable write and registered read, one access per cycle.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] idx,
    input  logic [3:0]    wr_en,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) begin
                mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (rd_en) begin
            rd_data <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, single-cycle response LATENCY cycles after the
// request cycle; busy holds off new requests. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
import dmem_pkg::*;

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_fun3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        lq_write;
    logic [2:0]  lq_fun3;
    logic [31:0] lq_addr;
    logic [31:0] lq_wdata;
    logic        err_q;

    logic        cur_write;
    logic [2:0]  cur_fun3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        accept, fire;
    logic        is_half, is_word, legal, in_range, req_err;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic [31:0] wr_lanes;
    logic [3:0]  arr_wr_en;
    logic        arr_rd_en;
    logic [31:0] arr_rd_data;

    // With LATENCY=1 the access happens on the accepting edge, before the latch holds the request
    assign cur_write = (state == IDLE) ? req_write : lq_write;
    assign cur_fun3  = (state == IDLE) ? req_fun3  : lq_fun3;
    assign cur_addr  = (state == IDLE) ? req_addr  : lq_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : lq_wdata;

    assign accept = (state == IDLE) && req_valid;
    assign fire   = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));

    always_comb begin
        is_half  = (cur_fun3[1:0] == 2'b01);
        is_word  = (cur_fun3[1:0] == 2'b10);
        legal    = cur_write ? (cur_fun3 inside {F3_B, F3_H, F3_W})
                             : (cur_fun3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        in_range = {2'b00, cur_addr[31:2]} < DEPTH_L;
`ifdef DMEM_MISALIGN_TRAP_EN
        req_err  = !legal || !in_range || (is_half && cur_addr[0])
                   || (is_word && (cur_addr[1:0] != 2'b00));
`else
        req_err  = !legal || !in_range;
`endif
        // Force-align: halves drop addr[0], words drop addr[1:0]
        if (is_word)      lane = 2'b00;
        else if (is_half) lane = {cur_addr[1], 1'b0};
        else              lane = cur_addr[1:0];

        case (cur_fun3[1:0])
            2'b00: begin
                be       = 4'b0001 << lane;
                wr_lanes = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{cur_wdata[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                wr_lanes = cur_wdata;
            end
        endcase

        arr_wr_en = (fire && cur_write && !req_err) ? be : 4'b0000;
        arr_rd_en = fire && !cur_write && !req_err;
    end

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk     (clk),
        .idx     (cur_addr[AW+1:2]),
        .wr_en   (arr_wr_en),
        .wr_data (wr_lanes),
        .rd_en   (arr_rd_en),
        .rd_data (arr_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 4'd0;
            lq_write <= 1'b0;
            lq_fun3  <= 3'd0;
            lq_addr  <= 32'd0;
            lq_wdata <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                lq_write <= req_write;
                lq_fun3  <= req_fun3;
                lq_addr  <= req_addr;
                lq_wdata <= req_wdata;
                cnt      <= LAT_M1;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (fire) err_q <= req_err;
        end
    end

    // In RESP the cur_* mux selects the latched request, so lane matches the access made
    always_comb begin
        busy       = (state != IDLE);
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && err_q;
        resp_rdata = 32'd0;
        if ((state == RESP) && !err_q && !lq_write) begin
            resp_rdata = lane_extract(arr_rd_data, lq_fun3, lane);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance carries the vector table,
// a LATENCY=1 instance sharing the request bus is checked in the throughput sequences.
module tb_dmem_responder;

    localparam int L2 = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write;
    logic [2:0]  req_fun3;
    logic [31:0] req_addr, req_wdata;
    logic        busy2, rv2, err2, busy1, rv1, err1;
    logic [31:0] rd2, rd1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(L2)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy2), .resp_valid(rv2), .resp_rdata(rd2), .resp_err(err2));

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy1), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1));

    typedef struct {
        logic        w;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[40];
    int   nv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] erd, input logic eerr);
        vecs[nv] = '{w: w, f: f, a: a, d: d, exp_rd: erd, exp_err: eerr};
        nv++;
    endtask

    // Presents one request to the LATENCY=2 instance; lat counts clock edges from the
    // edge that accepts it up to and including the cycle in which resp_valid is seen.
    task automatic run_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd, output logic er,
                           output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy2 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        req_write = w;
        req_fun3  = f;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        lat = 1;
        #1;
        req_valid = 1'b0;
        while (!rv2 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rv2) lat = 99;
        rd = rd2;
        er = err2;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [9:0]  m_rv2, m_rv1, m_b2, m_b1;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_fun3  = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        #12;
        check("reset_busy", {31'd0, busy2}, 32'd0);
        check("reset_resp_valid", {31'd0, rv2}, 32'd0);
        check("reset_resp_err", {31'd0, err2}, 32'd0);
        check("reset_resp_rdata", rd2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a store waits: store must be dropped
        run_req(1'b1, 3'b010, 32'h20, 32'h1111_1111, rd, er, lat);
        check("rst_seed_err", {31'd0, er}, 32'd0);
        repeat (2) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_fun3 = 3'b010;
        req_addr  = 32'h20; req_wdata = 32'h2222_2222;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rst_mid_busy_before", {31'd0, busy2}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy2}, 32'd0);
        check("rst_mid_resp_valid", {31'd0, rv2}, 32'd0);
        check("rst_mid_resp_err", {31'd0, err2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat);
        check("rst_old_rdata", rd, 32'h1111_1111);
        check("rst_old_err", {31'd0, er}, 32'd0);

        add(1, 3'b010, 32'h10,   32'hDEAD_BEEF, 32'h0,         0);
        add(0, 3'b010, 32'h10,   32'h0,         32'hDEAD_BEEF, 0);
        add(0, 3'b000, 32'h13,   32'h0,         32'hFFFF_FFDE, 0);
        add(0, 3'b100, 32'h13,   32'h0,         32'h0000_00DE, 0);
        add(0, 3'b101, 32'h12,   32'h0,         32'h0000_DEAD, 0);
        add(0, 3'b001, 32'h10,   32'h0,         32'hFFFF_BEEF, 0);
        add(0, 3'b000, 32'h10,   32'h0,         32'hFFFF_FFEF, 0);
        add(0, 3'b100, 32'h11,   32'h0,         32'h0000_00BE, 0);
        add(1, 3'b000, 32'h11,   32'h1234_5677, 32'h0,         0);
        add(0, 3'b010, 32'h10,   32'h0,         32'hDEAD_77EF, 0);
        add(1, 3'b010, 32'h14,   32'h0102_0304, 32'h0,         0);
        add(1, 3'b001, 32'h16,   32'hFFFF_8001, 32'h0,         0);
        add(0, 3'b010, 32'h14,   32'h0,         32'h8001_0304, 0);
        add(0, 3'b001, 32'h16,   32'h0,         32'hFFFF_8001, 0);
        add(0, 3'b101, 32'h16,   32'h0,         32'h0000_8001, 0);
        add(0, 3'b000, 32'h14,   32'h0,         32'h0000_0004, 0);
        add(0, 3'b010, 32'h12,   32'h0,         TRAP ? 32'h0 : 32'hDEAD_77EF, TRAP);
        add(0, 3'b001, 32'h11,   32'h0,         TRAP ? 32'h0 : 32'h0000_77EF, TRAP);
        add(1, 3'b010, 32'h13,   32'hCAFE_F00D, 32'h0,         TRAP);
        add(0, 3'b010, 32'h10,   32'h0,         TRAP ? 32'hDEAD_77EF : 32'hCAFE_F00D, 0);
        add(0, 3'b010, 32'h1000, 32'h0,         32'h0,         1);
        add(1, 3'b010, 32'h0,    32'h5555_5555, 32'h0,         0);
        add(1, 3'b010, 32'h1000, 32'hAAAA_AAAA, 32'h0,         1);
        add(0, 3'b010, 32'h0,    32'h0,         32'h5555_5555, 0);
        add(0, 3'b011, 32'h10,   32'h0,         32'h0,         1);
        add(0, 3'b110, 32'h0,    32'h0,         32'h0,         1);
        add(0, 3'b111, 32'h0,    32'h0,         32'h0,         1);
        add(1, 3'b011, 32'h0,    32'h0,         32'h0,         1);
        add(1, 3'b100, 32'h0,    32'h0,         32'h0,         1);
        add(0, 3'b010, 32'h0,    32'h0,         32'h5555_5555, 0);
        add(1, 3'b010, 32'hFFC,  32'h0BAD_F00D, 32'h0,         0);
        add(0, 3'b010, 32'hFFC,  32'h0,         32'h0BAD_F00D, 0);

        for (int i = 0; i < nv; i++) begin
            run_req(vecs[i].w, vecs[i].f, vecs[i].a, vecs[i].d, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(L2));
        end

        // req_valid held high for 9 cycles of SW 0x30 with wdata = cycle number
        repeat (2) @(negedge clk);
        m_rv2 = '0; m_rv1 = '0; m_b2 = '0; m_b1 = '0;
        for (int e = 1; e <= 10; e++) begin
            req_valid = (e <= 9);
            req_write = 1'b1;
            req_fun3  = 3'b010;
            req_addr  = 32'h30;
            req_wdata = 32'(e);
            @(posedge clk);
            #1;
            m_rv2[e-1] = rv2;
            m_rv1[e-1] = rv1;
            m_b2[e-1]  = busy2;
            m_b1[e-1]  = busy1;
            @(negedge clk);
        end
        check("hold_l2_resp_pattern", {22'd0, m_rv2}, 32'h092);
        check("hold_l2_busy_pattern", {22'd0, m_b2},  32'h0DB);
        check("hold_l1_resp_pattern", {22'd0, m_rv1}, 32'h155);
        check("hold_l1_busy_pattern", {22'd0, m_b1},  32'h155);

        // Last accepted store: cycle 7 for LATENCY=2, cycle 9 for LATENCY=1
        req_valid = 1'b1; req_write = 1'b0; req_fun3 = 3'b010;
        req_addr  = 32'h30; req_wdata = 32'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("hold_l1_resp_next_cycle", {31'd0, rv1}, 32'd1);
        check("hold_l1_rdata", rd1, 32'd9);
        @(posedge clk);
        #1;
        check("hold_l2_resp_valid", {31'd0, rv2}, 32'd1);
        check("hold_l2_rdata", rd2, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
